// File: rtl/screen_controller.sv
// Screen flow FSM (splash/play/game-over/win) with registered pixel mux.
// Define SCREEN_CONTROLLER_BLINK_EN to blink the non-play screens.
module screen_controller #(
    parameter int          OVER_FRAMES  = 120,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [3:0]  WIN_SCORE    = 4'd9,
    parameter logic [7:0]  SPLASH_RGB   = 8'h1F,
    parameter logic [7:0]  OVER_RGB     = 8'hE0,
    parameter logic [7:0]  WIN_RGB      = 8'h1C
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       key5IsPressed,
    input  logic [3:0] life,
    input  logic [3:0] score,
    input  logic [7:0] RGB_screen_main,
    output logic       game_resetN,
    output logic [7:0] RGB_out,
    output logic [1:0] screen_state
);

    typedef enum logic [1:0] {
        S_SPLASH = 2'd0,
        S_PLAY   = 2'd1,
        S_OVER   = 2'd2,
        S_WIN    = 2'd3
    } state_t;

    localparam logic [7:0] LP_OVER = 8'(OVER_FRAMES);

    state_t     r_state;
    state_t     w_next;
    logic       r_key_prev;
    logic [7:0] r_frame_cnt;
    logic [7:0] r_rgb;
    logic [7:0] w_rgb;
    logic       w_press;
    logic       w_change;
    logic       w_frame_done;

    assign w_press      = key5IsPressed & ~r_key_prev;
    assign w_change     = (w_next != r_state);
    assign w_frame_done = (r_frame_cnt == LP_OVER);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_SPLASH: begin
                if (w_press)
                    w_next = S_PLAY;
            end
            S_PLAY: begin
                // Losing takes priority over winning in the same frame
                if (startOfFrame) begin
                    if (life == 4'd0)
                        w_next = S_OVER;
                    else if (score >= WIN_SCORE)
                        w_next = S_WIN;
                end
            end
            S_OVER, S_WIN: begin
                if (w_press && w_frame_done)
                    w_next = S_SPLASH;
            end
            default: w_next = S_SPLASH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            r_state     <= S_SPLASH;
            r_key_prev  <= 1'b1;
            r_frame_cnt <= 8'd0;
        end else begin
            r_state    <= w_next;
            r_key_prev <= key5IsPressed;
            if (w_change)
                r_frame_cnt <= 8'd0;
            else if (startOfFrame && !w_frame_done &&
                     (r_state == S_OVER || r_state == S_WIN))
                r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

`ifdef SCREEN_CONTROLLER_BLINK_EN
    localparam logic [7:0] LP_BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [7:0] r_blink_cnt;
    logic       r_blink_phase;

    // Each new screen restarts with its colour visible
    always_ff @(posedge clk) begin
        if (resetN || w_change) begin
            r_blink_cnt   <= 8'd0;
            r_blink_phase <= 1'b1;
        end else if (startOfFrame) begin
            if (r_blink_cnt == LP_BLINK_LAST) begin
                r_blink_cnt   <= 8'd0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 8'd1;
            end
        end
    end
`endif

    always_comb begin
        w_rgb = 8'h00;
        case (r_state)
            S_PLAY:   w_rgb = RGB_screen_main;
            S_SPLASH: w_rgb = SPLASH_RGB;
            S_OVER:   w_rgb = OVER_RGB;
            S_WIN:    w_rgb = WIN_RGB;
            default:  w_rgb = 8'h00;
        endcase
`ifdef SCREEN_CONTROLLER_BLINK_EN
        if (r_state != S_PLAY && !r_blink_phase)
            w_rgb = 8'h00;
`endif
    end

    always_ff @(posedge clk) begin
        if (resetN)
            r_rgb <= 8'h00;
        else
            r_rgb <= w_rgb;
    end

    assign RGB_out      = r_rgb;
    assign screen_state = r_state;
    assign game_resetN  = (r_state == S_PLAY);

endmodule

// File: tb/tb_screen_controller.sv
// Randomized scoreboard bench for screen_controller.
// Reference model counts frames since screen entry.
module tb_screen_controller;

    localparam int         P_OVER  = 4;
    localparam int         P_BLINK = 2;
    localparam logic [3:0] P_WIN   = 4'd9;

    logic       clk;
    logic       resetN;
    logic       startOfFrame;
    logic       key5IsPressed;
    logic [3:0] life;
    logic [3:0] score;
    logic [7:0] RGB_screen_main;
    logic       game_resetN;
    logic [7:0] RGB_out;
    logic [1:0] screen_state;

    screen_controller #(
        .OVER_FRAMES  (P_OVER),
        .BLINK_FRAMES (P_BLINK),
        .WIN_SCORE    (P_WIN),
        .SPLASH_RGB   (8'h1F),
        .OVER_RGB     (8'hE0),
        .WIN_RGB      (8'h1C)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .key5IsPressed   (key5IsPressed),
        .life            (life),
        .score           (score),
        .RGB_screen_main (RGB_screen_main),
        .game_resetN     (game_resetN),
        .RGB_out         (RGB_out),
        .screen_state    (screen_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic       gr;
        logic [7:0] rgb;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: current screen, SOFs seen since entering it,
    // and the last key level seen
    int m_st = 0;
    int m_n  = 0;
    bit m_kp = 1'b1;

    function automatic logic [7:0] colour(input int st, input int n,
                                          input logic [7:0] px);
        logic [7:0] c;
        bit         on;
        case (st)
            1:       c = px;
            2:       c = 8'hE0;
            3:       c = 8'h1C;
            default: c = 8'h1F;
        endcase
`ifdef SCREEN_CONTROLLER_BLINK_EN
        on = ((n / P_BLINK) % 2) == 0;
`else
        on = 1'b1;
`endif
        if (st != 1 && !on)
            c = 8'h00;
        return c;
    endfunction

    task automatic step(input logic rst, input logic sof, input logic key,
                        input logic [3:0] lf, input logic [3:0] sc,
                        input logic [7:0] px);
        exp_t e;
        int   nst;
        bit   press;
        @(negedge clk);
        resetN          = rst;
        startOfFrame    = sof;
        key5IsPressed   = key;
        life            = lf;
        score           = sc;
        RGB_screen_main = px;
        if (rst) begin
            m_st  = 0;
            m_n   = 0;
            m_kp  = 1'b1;
            e.rgb = 8'h00;
        end else begin
            press = key && !m_kp;
            m_kp  = key;
            e.rgb = colour(m_st, m_n, px);
            nst   = m_st;
            if (m_st == 0 && press)
                nst = 1;
            else if (m_st == 1 && sof && lf == 4'd0)
                nst = 2;
            else if (m_st == 1 && sof && sc >= P_WIN)
                nst = 3;
            else if (m_st >= 2 && press && m_n >= P_OVER)
                nst = 0;
            if (nst != m_st)
                m_n = 0;
            else if (sof)
                m_n++;
            m_st = nst;
        end
        e.st = 2'(m_st);
        e.gr = (m_st == 1);
        q.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents a state/pixel
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (screen_state !== e.st) begin
                    errors++;
                    $display("FAIL state t=%0t got=%0d exp=%0d",
                             $time, screen_state, e.st);
                end
                checks++;
                if (game_resetN !== e.gr) begin
                    errors++;
                    $display("FAIL game_resetN t=%0t got=%0b exp=%0b",
                             $time, game_resetN, e.gr);
                end
                checks++;
                if (RGB_out !== e.rgb) begin
                    errors++;
                    $display("FAIL rgb t=%0t got=%02h exp=%02h",
                             $time, RGB_out, e.rgb);
                end
            end
        end
    end

    logic kreg;

    initial begin
        resetN = 1'b1; startOfFrame = 1'b0; key5IsPressed = 1'b1;
        life = 4'd3; score = 4'd0; RGB_screen_main = 8'h00;
        // Key held through reset and its release: no press
        repeat (3) step(1, 0, 1, 3, 0, 8'h00);
        repeat (3) step(0, 0, 1, 3, 0, 8'h00);
        step(0, 1, 1, 3, 0, 8'h00);
        step(0, 0, 0, 3, 0, 8'h00);
        step(0, 0, 1, 3, 0, 8'h00);
        step(0, 0, 1, 3, 0, 8'hA5);
        step(0, 0, 0, 3, 0, 8'h5A);
        step(0, 0, 1, 3, 0, 8'h3C);
        // Life drops mid-frame, acted on only at the next SOF
        repeat (3) step(0, 0, 0, 0, 0, 8'h11);
        step(0, 1, 0, 0, 0, 8'h22);
        // Three frames, then a press that must be ignored
        repeat (3) begin
            step(0, 1, 0, 3, 0, 8'h00);
            step(0, 0, 0, 3, 0, 8'h00);
        end
        step(0, 0, 1, 3, 0, 8'h00);
        step(0, 0, 0, 3, 0, 8'h00);
        step(0, 1, 0, 3, 0, 8'h00);
        step(0, 0, 1, 3, 0, 8'h00);
        step(0, 0, 0, 3, 0, 8'h00);
        // Splash blink sequence across several frames
        repeat (6) begin
            step(0, 1, 0, 3, 0, 8'h00);
            step(0, 0, 0, 3, 0, 8'h00);
        end
        // Lose and win in the same frame
        step(0, 0, 1, 3, 0, 8'h00);
        step(0, 0, 1, 3, 0, 8'h77);
        step(0, 1, 1, 0, 9, 8'h88);
        repeat (3) step(0, 1, 0, 3, 0, 8'h00);
        // Reset mid-GAME_OVER, then mid-PLAY
        step(1, 0, 0, 3, 0, 8'h00);
        step(0, 0, 0, 3, 0, 8'h00);
        step(0, 0, 1, 3, 0, 8'h00);
        step(0, 0, 1, 3, 0, 8'hA5);
        step(1, 0, 1, 3, 0, 8'hA5);
        step(0, 0, 1, 3, 0, 8'hA5);
        // Win path
        step(0, 0, 0, 3, 0, 8'h00);
        step(0, 0, 1, 3, 0, 8'h00);
        step(0, 1, 0, 3, 4'd12, 8'h00);
        repeat (10) step(0, 1, 0, 3, 0, 8'h00);
        step(0, 0, 1, 3, 0, 8'h00);
        step(0, 0, 0, 3, 0, 8'h00);
        // Randomized traffic
        kreg = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic       r, s;
            logic [3:0] lf, sc;
            r = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0)
                kreg = ~kreg;
            lf = ($urandom_range(0, 11) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            sc = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15))
                                             : 4'($urandom_range(0, 8));
            step(r, s, kreg, lf, sc, 8'($urandom));
        end
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/screen_controller.md
SCREEN_CONTROLLER -- requirements
Module: screen_controller

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- OVER_FRAMES, 120, frames the GAME_OVER/WIN screens ignore key5 (1..255).
- BLINK_FRAMES, 30, frames per blink half-period (1..255).
- WIN_SCORE, 4'd9, score at or above which the game is won.
- SPLASH_RGB, 8'h1F, splash colour.
- OVER_RGB, 8'hE0, game-over colour.
- WIN_RGB, 8'h1C, win colour.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, input, 1, system clock; the only clock.
- resetN, input, 1, synchronous reset, active-high: asserted at 1, sampled on the rising edge of clk.
- startOfFrame, input, 1, one-cycle pulse at frame start.
- key5IsPressed, input, 1, start/continue key, level.
- life, input, 4, remaining lives from screen_main.
- score, input, 4, current score from screen_main.
- RGB_screen_main, input, 8, game pixel from screen_main.
- game_resetN, output, 1, active-low reset driven into screen_main.
- RGB_out, output, 8, pixel sent to the VGA stage.
- screen_state, output, 2, 0=SPLASH, 1=PLAY, 2=GAME_OVER, 3=WIN.

Function
REQ-003 The block SHALL implement a four-state FSM: SPLASH, PLAY, GAME_OVER, WIN, held in screen_state.
REQ-004 The block SHALL detect key5 presses as rising edges: key5IsPressed=1 while the registered previous value is 0. A held key SHALL count as a single press.
REQ-005 SPLASH SHALL go to PLAY on the cycle after a key5 press.
REQ-006 PLAY SHALL sample life and score only on startOfFrame:
- life==0 -> GAME_OVER.
- score>=WIN_SCORE -> WIN.
- If both hold in the same frame, GAME_OVER SHALL win.
REQ-007 On entry to GAME_OVER or WIN, an 8-bit frame counter SHALL clear to 0. It SHALL then increment on each startOfFrame and saturate at OVER_FRAMES.
REQ-008 GAME_OVER/WIN SHALL ignore key5 until the counter equals OVER_FRAMES. After that, a key5 press SHALL go to SPLASH.
REQ-009 game_resetN SHALL be 1 only in PLAY and 0 in all other states. Every PLAY entry therefore starts screen_main from its reset values.
REQ-010 RGB_out SHALL be registered with 1-cycle latency from RGB_screen_main and from screen_state. Its value by state:
- PLAY: RGB_screen_main.
- SPLASH: SPLASH_RGB or 8'h00 per blink phase.
- GAME_OVER: OVER_RGB or 8'h00 per blink phase.
- WIN: WIN_RGB or 8'h00 per blink phase.
REQ-011 Blink logic SHALL work as follows:
- An 8-bit counter increments on startOfFrame.
- On reaching BLINK_FRAMES-1 it SHALL wrap to 0 and toggle blink_phase.
- blink_phase=1 selects the colour; blink_phase=0 selects 8'h00.
- The counter and phase SHALL clear on every state change, so each screen starts with the colour shown.
REQ-012 key5 presses occurring in PLAY SHALL have no effect on the FSM.

Reset
REQ-013 With resetN=1 at a clock edge, the following SHALL hold on the next cycle:
- screen_state=SPLASH.
- game_resetN=0.
- RGB_out=8'h00.
- All counters=0.
- blink_phase=1.
- Previous-key register=1, so a key already held through reset is not a press.
REQ-014 A reset asserted mid-PLAY or mid-GAME_OVER SHALL return the block to SPLASH with no intermediate state visible on screen_state.

Configuration
REQ-015 Macro SCREEN_CONTROLLER_BLINK_EN:
- Defined: REQ-011 blinking applies.
- Undefined: the blink counter and blink_phase SHALL be compiled out, and SPLASH/GAME_OVER/WIN SHALL show their colour constantly.
- Either way, FSM timing SHALL be identical.

Verification
REQ-016 Reset, then hold key5 high through reset release -> state stays SPLASH; release, then press -> state=PLAY one cycle later and game_resetN=1.
REQ-017 PLAY, life drops to 0 mid-frame -> no change until the next startOfFrame, then state=GAME_OVER and game_resetN=0.
REQ-018 PLAY, life=0 and score=9 at the same startOfFrame -> state=GAME_OVER, not WIN.
REQ-019 GAME_OVER with OVER_FRAMES=4: a press after 3 frames is ignored; a press after the 4th frame gives state=SPLASH.
REQ-020 With blink enabled and BLINK_FRAMES=2 in SPLASH:
- RGB_out follows the sequence 1F, 1F, 00, 00, 1F, … per frame pair.
- Without the macro, RGB_out stays at 8'h1F.
REQ-021 In PLAY, drive RGB_screen_main=8'hA5 -> RGB_out=8'hA5 exactly one clk later; assert resetN mid-PLAY -> RGB_out=8'h00 and state=SPLASH.
